// File: rtl/riscv_wb_checker.sv
// riscv_wb_checker: shadow register file fed from the core writeback port,
// compared against a programmed expectation table after halt or timeout.
module riscv_wb_checker #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter int NUM_CHECKS     = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int REG_W = $clog2(NUM_REGS),
  localparam int IDX_W = $clog2(NUM_CHECKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [REG_W-1:0] cfg_addr,
  input  logic [XLEN-1:0]  cfg_data,
  input  logic             start,
  input  logic             halt,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [IDX_W:0]   fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [XLEN-1:0]  first_fail_got
);

  localparam int FC_W  = IDX_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHECKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [XLEN-1:0]  shadow   [NUM_REGS];
  logic             tbl_en   [NUM_CHECKS];
  logic [REG_W-1:0] tbl_addr [NUM_CHECKS];
  logic [XLEN-1:0]  tbl_data [NUM_CHECKS];

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] chk_idx;

  logic             idle_like;
  logic             launch;
  logic             cnt_hit;
  logic             chk_last;
  logic [XLEN-1:0]  chk_val;
  logic             miss;
  logic [FC_W-1:0]  fail_nx;

  assign busy      = (state == S_RUN) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign launch    = idle_like && start;
  assign cnt_hit   = (cnt == CNT_LAST);
  assign chk_last  = (chk_idx == IDX_LAST);
  assign chk_val   = shadow[tbl_addr[chk_idx]];
  assign miss      = (state == S_CHECK) && tbl_en[chk_idx] &&
                     (chk_val != tbl_data[chk_idx]);
  assign fail_nx   = fail_count + FC_W'(miss);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE,
      S_DONE: begin
        if (start) state_nx = S_RUN;
      end
      S_RUN: begin
        if (halt || cnt_hit) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (chk_last) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // x0 is never written, so shadow[0] reads back 0 for free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (launch) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if ((state == S_RUN) && wb_en && (wb_addr != '0)) begin
      shadow[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_en[i]   <= 1'b0;
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      tbl_en[cfg_idx]   <= cfg_en;
      tbl_addr[cfg_idx] <= cfg_addr;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      chk_idx        <= '0;
      timeout        <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      pass           <= 1'b0;
    end else if (launch) begin
      cnt            <= '0;
      chk_idx        <= '0;
      timeout        <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      pass           <= 1'b0;
    end else begin
      if (state == S_RUN) begin
        cnt <= cnt + CNT_W'(1);
        // halt on the budget edge wins over the timeout
        if (!halt && cnt_hit) timeout <= 1'b1;
      end
      if (state == S_CHECK) begin
        chk_idx    <= chk_idx + IDX_W'(1);
        fail_count <= fail_nx;
        if (miss && (fail_count == '0)) begin
          first_fail_idx <= chk_idx;
          first_fail_got <= chk_val;
        end
        if (chk_last) pass <= (fail_nx == '0) && !timeout;
      end
    end
  end

endmodule

// File: tb/tb_riscv_wb_checker.sv
// Bench for riscv_wb_checker: event-level model of run/check outcomes
// plus directed scenarios with literal expectations.
module tb_riscv_wb_checker;

  localparam int N  = 8;
  localparam int T  = 16;
  localparam int IW = 3;
  localparam int RW = 5;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          cfg_we   = 1'b0;
  logic [IW-1:0] cfg_idx  = '0;
  logic          cfg_en   = 1'b0;
  logic [RW-1:0] cfg_addr = '0;
  logic [31:0]   cfg_data = '0;
  logic          start    = 1'b0;
  logic          halt     = 1'b0;
  logic          wb_en    = 1'b0;
  logic [RW-1:0] wb_addr  = '0;
  logic [31:0]   wb_data  = '0;

  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [IW:0]   fail_count;
  logic [IW-1:0] first_fail_idx;
  logic [31:0]   first_fail_got;

  riscv_wb_checker #(
    .XLEN(32),
    .NUM_REGS(32),
    .NUM_CHECKS(N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_en(cfg_en),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .start(start),
    .halt(halt),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .fail_count(fail_count),
    .first_fail_idx(first_fail_idx),
    .first_fail_got(first_fail_got)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model: table, shadow, and the edge numbers bounding the current run
  bit          m_en   [N];
  int          m_addr [N];
  logic [31:0] m_data [N];
  logic [31:0] m_sh   [32];
  bit          m_started = 1'b0;
  int          m_k       = 0;
  int          m_end     = 0;
  bit          m_to      = 1'b0;
  bit          m_snap    = 1'b0;

  bit          e_pass;
  bit          e_to;
  int          e_fc;
  int          e_ffi;
  logic [31:0] e_ffg;

  function automatic bit exp_busy(int c);
    return m_started && (c >= m_k) && (c < m_end + N);
  endfunction

  function automatic bit exp_done(int c);
    return m_started && (c >= m_end + N);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_en[i]   = 1'b0;
      m_addr[i] = 0;
      m_data[i] = '0;
    end
    for (int i = 0; i < 32; i++) m_sh[i] = '0;
    m_started = 1'b0;
    m_snap    = 1'b0;
  endfunction

  function automatic void snapshot();
    e_fc  = 0;
    e_ffi = 0;
    e_ffg = '0;
    for (int i = 0; i < N; i++) begin
      if (m_en[i] && (m_sh[m_addr[i]] !== m_data[i])) begin
        if (e_fc == 0) begin
          e_ffi = i;
          e_ffg = m_sh[m_addr[i]];
        end
        e_fc++;
      end
    end
    e_to   = m_to;
    e_pass = (e_fc == 0) && !m_to;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, exp);
    end
  endtask

  // model update at each sampled edge
  initial begin
    int e;
    bit was_busy;
    bit in_run;
    model_clear();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_clear();
      end else begin
        e        = cyc + 1;
        was_busy = exp_busy(cyc);
        in_run   = m_started && (e > m_k) && (e <= m_end);
        if (cfg_we && !was_busy) begin
          m_en[cfg_idx]   = cfg_en;
          m_addr[cfg_idx] = int'(cfg_addr);
          m_data[cfg_idx] = cfg_data;
        end
        if (in_run) begin
          if (wb_en && (wb_addr != '0)) m_sh[wb_addr] = wb_data;
          if (halt) begin
            m_end = e;
            m_to  = 1'b0;
          end
        end
        if (start && !was_busy) begin
          for (int i = 0; i < 32; i++) m_sh[i] = '0;
          m_started = 1'b1;
          m_k       = e;
          m_end     = e + T;
          m_to      = 1'b1;
          m_snap    = 1'b0;
        end
      end
      cyc = cyc + 1;
    end
  end

  // compare process
  initial forever begin
    @(negedge clk);
    chk("busy", busy, exp_busy(cyc));
    chk("done", done, exp_done(cyc));
    if (m_started && !m_snap && (cyc >= m_end)) begin
      snapshot();
      m_snap = 1'b1;
    end
    if (exp_done(cyc)) begin
      chk("pass", pass, e_pass);
      chk("timeout", timeout, e_to);
      chk("fail_count", fail_count, e_fc);
      chk("first_fail_idx", first_fail_idx, e_ffi);
      chk("first_fail_got", first_fail_got, e_ffg);
    end else if (!m_started) begin
      chk("idle_pass", pass, 0);
      chk("idle_timeout", timeout, 0);
      chk("idle_fail_count", fail_count, 0);
      chk("idle_ffi", first_fail_idx, 0);
      chk("idle_ffg", first_fail_got, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int idx, bit en, int addr, logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_idx  = IW'(idx);
    cfg_en   = en;
    cfg_addr = RW'(addr);
    cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic go(output int k);
    start = 1'b1;
    step();
    k     = cyc;
    start = 1'b0;
  endtask

  task automatic wb(int a, logic [31:0] d);
    wb_en   = 1'b1;
    wb_addr = RW'(a);
    wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic do_halt(bit w, int a, logic [31:0] d, output int h);
    halt    = 1'b1;
    wb_en   = w;
    wb_addr = RW'(a);
    wb_data = d;
    step();
    h     = cyc;
    halt  = 1'b0;
    wb_en = 1'b0;
  endtask

  task automatic wait_done(int max, output int d);
    int n = 0;
    while (!done && n < max) begin
      step();
      n++;
    end
    d = cyc;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: no done within %0d cycles", max);
    end
  endtask

  initial begin
    int k;
    int h;
    int d;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_count", fail_count, 0);
    rst_n = 1'b1;
    step();

    // basic pass
    cfg(0, 1, 3, 32'd1);
    cfg(1, 1, 4, 32'd4);
    cfg(2, 1, 5, 32'd5);
    go(k);
    wb(3, 32'd1);
    wb(4, 32'd4);
    wb(5, 32'd5);
    do_halt(0, 0, 0, h);
    wait_done(40, d);
    chk("basic_latency", d - h, N);
    chk("basic_pass", pass, 1);
    chk("basic_fc", fail_count, 0);
    step();

    // single mismatch
    go(k);
    wb(3, 32'd1);
    wb(4, 32'd7);
    wb(5, 32'd5);
    do_halt(0, 0, 0, h);
    wait_done(40, d);
    chk("mm_pass", pass, 0);
    chk("mm_fc", fail_count, 1);
    chk("mm_ffi", first_fail_idx, 1);
    chk("mm_ffg", first_fail_got, 7);

    // three mismatches, first at entry 0
    go(k);
    wb(3, 32'd2);
    wb(4, 32'd7);
    do_halt(0, 0, 0, h);
    wait_done(40, d);
    chk("mm3_fc", fail_count, 3);
    chk("mm3_ffi", first_fail_idx, 0);
    chk("mm3_ffg", first_fail_got, 2);

    // x0 drop and same-cycle overwrite on halt
    cfg(0, 1, 0, 32'd0);
    cfg(1, 1, 6, 32'd9);
    cfg(2, 0, 0, 32'd0);
    go(k);
    wb(0, 32'hFFFF_FFFF);
    wb(6, 32'd3);
    do_halt(1, 6, 32'd9, h);
    wait_done(40, d);
    chk("x0_pass", pass, 1);
    chk("x0_fc", fail_count, 0);

    // timeout with all entries matching
    cfg(0, 1, 7, 32'h1234_5678);
    cfg(1, 0, 0, 32'd0);
    go(k);
    wb(7, 32'h1234_5678);
    wait_done(60, d);
    chk("to_latency", d - k, T + N);
    chk("to_timeout", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_fc", fail_count, 0);

    // halt on the very edge the budget expires
    go(k);
    wb(7, 32'h1234_5678);
    repeat (T - 2) step();
    do_halt(0, 0, 0, h);
    chk("edge_halt_at", h - k, T);
    wait_done(40, d);
    chk("edge_latency", d - h, N);
    chk("edge_timeout", timeout, 0);
    chk("edge_pass", pass, 1);

    // busy gating: cfg and start during RUN
    cfg(0, 1, 8, 32'hA5);
    go(k);
    wb(8, 32'hA5);
    cfg(0, 1, 8, 32'hDEAD);
    go(h);
    do_halt(0, 0, 0, h);
    wait_done(40, d);
    chk("gate_latency", d - k, 4 + N);
    chk("gate_pass", pass, 1);

    // async reset while DONE
    step();
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_done_done", done, 0);
    chk("rst_done_pass", pass, 0);
    step();
    rst_n = 1'b1;
    step();

    // async reset mid-RUN
    cfg(0, 1, 9, 32'd1);
    go(k);
    wb(9, 32'd1);
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_run_busy", busy, 0);
    chk("rst_run_done", done, 0);
    chk("rst_run_pass", pass, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    go(k);
    do_halt(0, 0, 0, h);
    wait_done(40, d);
    chk("post_rst_pass", pass, 1);
    chk("post_rst_fc", fail_count, 0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
